// File: rtl/scarv_cop_malu_seq_pkg.sv
// scarv_cop_malu_seq_pkg
// MP subclass codes and sequencer states.
package scarv_cop_malu_seq_pkg;

   localparam logic [3:0] MP_EQU  = 4'd0;
   localparam logic [3:0] MP_LTU  = 4'd1;
   localparam logic [3:0] MP_GTU  = 4'd2;
   localparam logic [3:0] MP_ADD3 = 4'd3;
   localparam logic [3:0] MP_ADD2 = 4'd4;
   localparam logic [3:0] MP_SUB3 = 4'd5;
   localparam logic [3:0] MP_SUB2 = 4'd6;
   localparam logic [3:0] MP_SLLI = 4'd7;
   localparam logic [3:0] MP_SRLI = 4'd8;
   localparam logic [3:0] MP_SLL  = 4'd9;
   localparam logic [3:0] MP_SRL  = 4'd10;
   localparam logic [3:0] MP_ACC2 = 4'd11;
   localparam logic [3:0] MP_ACC1 = 4'd12;
   localparam logic [3:0] MP_MAC  = 4'd13;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_EXEC = 2'd1,
      SEQ_RESP = 2'd2
   } seq_state_t;

   function automatic logic mp_legal(input logic [3:0] s);
      return s <= MP_MAC;
   endfunction

   function automatic logic mp_is_cmp(input logic [3:0] s);
      return s <= MP_GTU;
   endfunction

endpackage

// File: rtl/scarv_cop_malu_seq.sv
// scarv_cop_malu_seq
// Issues one MP instruction to the MP-ALU and sequences its writeback.
module scarv_cop_malu_seq
   import scarv_cop_malu_seq_pkg::*;
#(
   parameter int CPR_AW = 4,
   parameter int WDOG   = 7
) (
   input  logic              g_clk,
   input  logic              g_reset,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [3:0]        id_subclass,
   input  logic [31:0]       id_imm,
   input  logic [CPR_AW-1:0] id_crs1,
   input  logic [CPR_AW-1:0] id_crs2,
   input  logic [CPR_AW-1:0] id_crs3,
   input  logic [CPR_AW-1:0] id_crd,
   output logic              malu_ivalid,
   input  logic              malu_idone,
   input  logic              malu_rdm_in_rs,
   output logic [31:0]       malu_imm,
   output logic [3:0]        malu_subclass,
   output logic [31:0]       malu_rs1,
   output logic [31:0]       malu_rs2,
   output logic [31:0]       malu_rs3,
   output logic [CPR_AW-1:0] cpr_ra1,
   output logic [CPR_AW-1:0] cpr_ra2,
   output logic [CPR_AW-1:0] cpr_ra3,
   input  logic [31:0]       cpr_rd1,
   input  logic [31:0]       cpr_rd2,
   input  logic [31:0]       cpr_rd3,
   input  logic [3:0]        malu_ben,
   input  logic [31:0]       malu_wdata,
   output logic              cpr_wen,
   output logic [CPR_AW-1:0] cpr_waddr,
   output logic [3:0]        cpr_wben,
   output logic [31:0]       cpr_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_data,
   output logic              rsp_err
);

   seq_state_t        state_q;
   seq_state_t        state_d;
   logic [3:0]        sub_q;
   logic [31:0]       imm_q;
   logic [CPR_AW-1:0] crs1_q;
   logic [CPR_AW-1:0] crs2_q;
   logic [CPR_AW-1:0] crs3_q;
   logic [CPR_AW-1:0] rdm_q;
   logic              wr_hi_q;
   logic [3:0]        wdog_q;
   logic [31:0]       rsp_data_q;
   logic              rsp_err_q;

   logic in_exec;
   logic wdog_hit;
   logic accept;
   logic rdm_sel;

   assign in_exec  = (state_q == SEQ_EXEC);
   assign wdog_hit = (wdog_q == 4'(WDOG));
   assign accept   = (state_q == SEQ_IDLE) && id_valid;
   assign rdm_sel  = in_exec && malu_rdm_in_rs;

   assign id_ready      = (state_q == SEQ_IDLE) && !g_reset;
   assign malu_ivalid   = in_exec && !wdog_hit;
   assign malu_imm      = imm_q;
   assign malu_subclass = sub_q;
   assign malu_rs1      = cpr_rd1;
   assign malu_rs2      = cpr_rd2;
   assign malu_rs3      = cpr_rd3;

   assign cpr_ra1 = crs1_q;
   assign cpr_ra2 = rdm_sel ? (rdm_q | CPR_AW'(1)) : crs2_q;
   assign cpr_ra3 = rdm_sel ? rdm_q : crs3_q;

   assign cpr_wen   = malu_ivalid && (|malu_ben);
   assign cpr_waddr = rdm_q | CPR_AW'(wr_hi_q);
   assign cpr_wben  = cpr_wen ? malu_ben : 4'h0;
   assign cpr_wdata = cpr_wen ? malu_wdata : 32'h0;

   assign rsp_valid = (state_q == SEQ_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   // Next-state selection: issue, execute with watchdog, hold response.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SEQ_IDLE: begin
            if (id_valid) begin
               state_d = mp_legal(id_subclass) ? SEQ_EXEC : SEQ_RESP;
            end
         end
         SEQ_EXEC: begin
            if (wdog_hit || malu_idone) begin
               state_d = SEQ_RESP;
            end
         end
         SEQ_RESP: begin
            if (rsp_ready) begin
               state_d = SEQ_IDLE;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // State, latched instruction fields, write-half toggle and response.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q    <= SEQ_IDLE;
         sub_q      <= '0;
         imm_q      <= '0;
         crs1_q     <= '0;
         crs2_q     <= '0;
         crs3_q     <= '0;
         rdm_q      <= '0;
         wr_hi_q    <= 1'b0;
         wdog_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sub_q      <= id_subclass;
            imm_q      <= id_imm;
            crs1_q     <= id_crs1;
            crs2_q     <= id_crs2;
            crs3_q     <= id_crs3;
            rdm_q      <= id_crd & ~CPR_AW'(1);
            wr_hi_q    <= 1'b0;
            wdog_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= !mp_legal(id_subclass);
         end
         if (malu_ivalid) begin
            wdog_q <= wdog_q + 4'd1;
            if (cpr_wen) begin
               wr_hi_q <= !wr_hi_q;
            end
            if (malu_idone && mp_is_cmp(sub_q)) begin
               rsp_data_q <= {31'h0, malu_wdata[0]};
            end
         end
         if (in_exec && wdog_hit) begin
            rsp_err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_scarv_cop_malu_seq.sv
// tb_scarv_cop_malu_seq
// Bench with CPR file, stub MP-ALU and arithmetic reference.
module tb_scarv_cop_malu_seq;
   import scarv_cop_malu_seq_pkg::*;

   localparam int WDOG = 7;

   logic        g_clk = 1'b0;
   logic        g_reset = 1'b1;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [3:0]  id_subclass = '0;
   logic [31:0] id_imm = '0;
   logic [3:0]  id_crs1 = '0;
   logic [3:0]  id_crs2 = '0;
   logic [3:0]  id_crs3 = '0;
   logic [3:0]  id_crd = '0;
   logic        malu_ivalid;
   logic        malu_idone;
   logic        malu_rdm_in_rs;
   logic [31:0] malu_imm;
   logic [3:0]  malu_subclass;
   logic [31:0] malu_rs1, malu_rs2, malu_rs3;
   logic [3:0]  cpr_ra1, cpr_ra2, cpr_ra3;
   logic [31:0] cpr_rd1, cpr_rd2, cpr_rd3;
   logic [3:0]  malu_ben;
   logic [31:0] malu_wdata;
   logic        cpr_wen;
   logic [3:0]  cpr_waddr;
   logic [3:0]  cpr_wben;
   logic [31:0] cpr_wdata;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        rsp_err;

   scarv_cop_malu_seq #(.CPR_AW(4), .WDOG(WDOG)) dut (
      .g_clk(g_clk), .g_reset(g_reset),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_subclass(id_subclass), .id_imm(id_imm),
      .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crs3(id_crs3),
      .id_crd(id_crd),
      .malu_ivalid(malu_ivalid), .malu_idone(malu_idone),
      .malu_rdm_in_rs(malu_rdm_in_rs),
      .malu_imm(malu_imm), .malu_subclass(malu_subclass),
      .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
      .cpr_ra1(cpr_ra1), .cpr_ra2(cpr_ra2), .cpr_ra3(cpr_ra3),
      .cpr_rd1(cpr_rd1), .cpr_rd2(cpr_rd2), .cpr_rd3(cpr_rd3),
      .malu_ben(malu_ben), .malu_wdata(malu_wdata),
      .cpr_wen(cpr_wen), .cpr_waddr(cpr_waddr),
      .cpr_wben(cpr_wben), .cpr_wdata(cpr_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 g_clk = ~g_clk;

   int n_chk = 0;
   int n_err = 0;

   function automatic int op_cycles(input logic [3:0] s);
      if (s <= MP_GTU) return 1;
      if (s == MP_ADD3 || s == MP_SUB3 || s == MP_ACC2 || s == MP_MAC)
         return 3;
      return 2;
   endfunction

   function automatic logic is_acc(input logic [3:0] s);
      return s == MP_ACC1 || s == MP_ACC2;
   endfunction

   // a=rs1, b=rs2, c=rs3; for accumulates b:c is the rd pair (hi:lo)
   function automatic logic [63:0] op_result(input logic [3:0] s,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] c, input logic [31:0] imm);
      logic [63:0] a6, b6, c6;
      a6 = {32'h0, a};
      b6 = {32'h0, b};
      c6 = {32'h0, c};
      case (s)
         MP_EQU:  return {63'h0, b == c};
         MP_LTU:  return {63'h0, b < c};
         MP_GTU:  return {63'h0, b > c};
         MP_ADD3: return a6 + b6 + c6;
         MP_ADD2: return a6 + b6;
         MP_SUB3: return a6 - b6 - c6;
         MP_SUB2: return a6 - b6;
         MP_SLLI: return a6 << imm[4:0];
         MP_SRLI: return {a, 32'h0} >> imm[4:0];
         MP_SLL:  return a6 << b[4:0];
         MP_SRL:  return {a, 32'h0} >> b[4:0];
         MP_ACC2: return {b, c} + a6;
         MP_ACC1: return {b, c} + a6;
         MP_MAC:  return a6 * b6 + c6;
         default: return 64'h0;
      endcase
   endfunction

   // CPR file with a bench-side preload port
   logic [31:0] cpr [16];
   logic        pl_en = 1'b0;
   logic [3:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   assign cpr_rd1 = cpr[cpr_ra1];
   assign cpr_rd2 = cpr[cpr_ra2];
   assign cpr_rd3 = cpr[cpr_ra3];

   always @(posedge g_clk) begin
      if (pl_en) begin
         cpr[pl_addr] <= pl_data;
      end else if (cpr_wen) begin
         for (int b = 0; b < 4; b++)
            if (cpr_wben[b]) cpr[cpr_waddr][8*b +: 8] <= cpr_wdata[8*b +: 8];
      end
   end

   // Stub MP-ALU: cmp answers in one cycle, others write lo then hi
   int          alu_step = 0;
   int          alu_n;
   logic [63:0] alu_res_q = '0;
   logic [63:0] alu_now;
   logic        alu_hang = 1'b0;

   always_comb begin
      alu_n = op_cycles(malu_subclass);
      alu_now = (alu_step == 0) ?
         op_result(malu_subclass, cpr_rd1, cpr_rd2, cpr_rd3, malu_imm) :
         alu_res_q;
      malu_idone = malu_ivalid && !alu_hang && (alu_step == alu_n - 1);
      malu_rdm_in_rs = malu_ivalid && is_acc(malu_subclass);
      malu_ben = 4'h0;
      malu_wdata = 32'h0;
      if (malu_ivalid && !alu_hang) begin
         if (malu_subclass <= MP_GTU) begin
            malu_wdata = {31'h0, alu_now[0]};
         end else if (alu_step == alu_n - 2) begin
            malu_ben = 4'hF;
            malu_wdata = alu_now[31:0];
         end else if (alu_step == alu_n - 1) begin
            malu_ben = 4'hF;
            malu_wdata = alu_now[63:32];
         end
      end
   end

   always @(posedge g_clk) begin
      if (g_reset || !malu_ivalid) begin
         alu_step <= 0;
      end else begin
         if (alu_step == 0) alu_res_q <= alu_now;
         alu_step <= malu_idone ? 0 : alu_step + 1;
      end
   end

   logic [31:0] mir [16];

   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pl(input logic [3:0] a, input logic [31:0] d);
      pl_en = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick();
      pl_en = 1'b0;
      mir[a] = d;
   endtask

   task automatic chk_regs(input string nm);
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++)
         if (cpr[i] !== mir[i]) bad++;
      chk(nm, bad, 0);
   endtask

   task automatic run_op(input logic [3:0] s, input logic [3:0] r1,
      input logic [3:0] r2, input logic [3:0] r3, input logic [3:0] rd,
      input logic [31:0] imm, input int hold, input bit early,
      output int lat, output int nv, output logic [31:0] data,
      output logic err, output bit ra_ok);
      int g;
      g = 0;
      while (!id_ready && g < 50) begin
         tick();
         g++;
      end
      if (!id_ready) chk("id_ready_wait", id_ready, 1);
      id_valid = 1'b1;
      id_subclass = s;
      id_imm = imm;
      id_crs1 = r1;
      id_crs2 = r2;
      id_crs3 = r3;
      id_crd = rd;
      rsp_ready = early;
      tick();
      id_valid = 1'b0;
      lat = 1;
      nv = 0;
      ra_ok = 1'b1;
      while (!rsp_valid && lat < 40) begin
         if (malu_ivalid) nv++;
         if (malu_rdm_in_rs &&
             (cpr_ra2 != (rd | 4'd1) || cpr_ra3 != (rd & 4'he)))
            ra_ok = 1'b0;
         tick();
         lat++;
      end
      data = rsp_data;
      err = rsp_err;
      for (int h = 0; h < hold; h++) begin
         rsp_ready = 1'b0;
         tick();
         chk("rsp_hold_valid", rsp_valid, 1);
         chk("rsp_hold_data", {rsp_err, rsp_data}, {err, data});
         chk("rsp_hold_idrdy", id_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("post_rsp_idle", {rsp_valid, id_ready}, 2'b01);
   endtask

   typedef struct {
      logic [3:0]  sub, r1, r2, r3, rd;
      logic [31:0] imm, v1, v2, v3, vlo, vhi;
      logic [31:0] e_lo, e_hi, e_data;
      int          e_lat, e_nv, hold;
      logic        e_err;
   } vec_t;

   vec_t vt[7];

   initial begin
      int lat, nv;
      logic [31:0] data;
      logic err;
      bit ra_ok;
      logic [3:0] s, rd, r1, r2, r3;
      logic [31:0] imm, b, c;
      logic [63:0] res;
      logic legal;
      int hold;
      bit early;

      vt[0] = '{MP_ADD2, 4'd2, 4'd3, 4'd3, 4'd5, 32'h0, 32'hFFFFFFFF, 32'h1,
                32'h1, 32'h11, 32'h22, 32'h0, 32'h1, 32'h0, 3, 2, 0, 1'b0};
      vt[1] = '{MP_MAC, 4'd1, 4'd2, 4'd3, 4'd6, 32'h0, 32'h10000, 32'h10000,
                32'h5, 32'h33, 32'h44, 32'h5, 32'h1, 32'h0, 4, 3, 0, 1'b0};
      vt[2] = '{MP_ACC1, 4'd1, 4'd1, 4'd1, 4'd9, 32'h0, 32'h1, 32'h1, 32'h1,
                32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 32'h0, 3, 2, 0, 1'b0};
      vt[3] = '{MP_LTU, 4'd1, 4'd10, 4'd11, 4'd14, 32'h0, 32'h0, 32'h3,
                32'h5, 32'h55, 32'h66, 32'h55, 32'h66, 32'h1, 2, 1, 5, 1'b0};
      vt[4] = '{4'hF, 4'd1, 4'd4, 4'd5, 4'd2, 32'h0, 32'h9, 32'h9, 32'h9,
                32'h7, 32'h8, 32'h7, 32'h8, 32'h0, 1, 0, 0, 1'b1};
      vt[5] = '{MP_SLLI, 4'd1, 4'd2, 4'd3, 4'd12, 32'h4, 32'h80000001,
                32'h0, 32'h0, 32'h1, 32'h2, 32'h10, 32'h8, 32'h0, 3, 2, 0,
                1'b0};
      vt[6] = '{MP_GTU, 4'd1, 4'd10, 4'd11, 4'd14, 32'h0, 32'h0, 32'h7,
                32'h5, 32'h55, 32'h66, 32'h55, 32'h66, 32'h1, 2, 1, 0, 1'b0};

      for (int i = 0; i < 16; i++) begin
         cpr[i] = 32'h0;
         mir[i] = 32'h0;
      end

      tick();
      tick();
      chk("reset_idrdy", id_ready, 0);
      g_reset = 1'b0;
      #1;
      chk("reset_outs", {id_ready, malu_ivalid, cpr_wen, rsp_valid, rsp_err},
          5'b10000);
      chk("reset_data", {rsp_data, malu_imm, malu_subclass}, 68'h0);

      for (int i = 0; i < 7; i++) begin
         pl(vt[i].rd & 4'he, vt[i].vlo);
         pl(vt[i].rd | 4'd1, vt[i].vhi);
         pl(vt[i].r1, vt[i].v1);
         pl(vt[i].r2, vt[i].v2);
         pl(vt[i].r3, vt[i].v3);
         run_op(vt[i].sub, vt[i].r1, vt[i].r2, vt[i].r3, vt[i].rd,
                vt[i].imm, vt[i].hold, 1'b0, lat, nv, data, err, ra_ok);
         mir[vt[i].rd & 4'he] = vt[i].e_lo;
         mir[vt[i].rd | 4'd1] = vt[i].e_hi;
         chk($sformatf("v%0d_lat", i), lat, vt[i].e_lat);
         chk($sformatf("v%0d_ivalid", i), nv, vt[i].e_nv);
         chk($sformatf("v%0d_rsp", i), {err, data}, {vt[i].e_err, vt[i].e_data});
         chk_regs($sformatf("v%0d_cpr", i));
         if (is_acc(vt[i].sub)) chk($sformatf("v%0d_ra", i), ra_ok, 1);
      end

      // watchdog: ALU never finishes
      pl(4'd4, 32'hAB);
      pl(4'd5, 32'hCD);
      alu_hang = 1'b1;
      run_op(MP_ADD2, 4'd1, 4'd2, 4'd3, 4'd4, 32'h0, 0, 1'b0,
             lat, nv, data, err, ra_ok);
      alu_hang = 1'b0;
      chk("wdog_lat", lat, WDOG + 2);
      chk("wdog_ivalid", nv, WDOG);
      chk("wdog_err", err, 1);
      chk_regs("wdog_cpr");

      // reset during ADD3 after first write
      pl(4'd1, 32'hFFFFFFFF);
      pl(4'd2, 32'h1);
      pl(4'd3, 32'h1);
      pl(4'd12, 32'hAAAA);
      pl(4'd13, 32'hBBBB);
      id_valid = 1'b1;
      id_subclass = MP_ADD3;
      id_imm = 32'h1234;
      id_crs1 = 4'd1;
      id_crs2 = 4'd2;
      id_crs3 = 4'd3;
      id_crd = 4'd12;
      tick();
      id_valid = 1'b0;
      chk("add3_issue", {malu_ivalid, malu_subclass, malu_imm},
          {1'b1, MP_ADD3, 32'h1234});
      chk("rs_pass", {malu_rs1, malu_rs2}, {32'hFFFFFFFF, 32'h1});
      tick();
      chk("add3_wr1", {cpr_wen, cpr_waddr}, {1'b1, 4'd12});
      g_reset = 1'b1;
      tick();
      chk("rst_exec", {malu_ivalid, cpr_wen, rsp_valid, id_ready}, 4'b0000);
      g_reset = 1'b0;
      #1;
      chk("rst_idle", id_ready, 1);
      mir[12] = 32'h1;
      tick();
      tick();
      chk_regs("rst_cpr");

      run_op(MP_ADD2, 4'd1, 4'd2, 4'd3, 4'd12, 32'h0, 0, 1'b1,
             lat, nv, data, err, ra_ok);
      mir[12] = 32'h0;
      mir[13] = 32'h1;
      chk("post_rst_add2", {lat, nv, 31'(err)}, {32'd3, 32'd2, 31'd0});
      chk_regs("post_rst_cpr");

      // randomized ops against the arithmetic reference
      for (int k = 0; k < 40; k++) begin
         s = 4'($urandom_range(0, 15));
         rd = 4'($urandom_range(0, 7) * 2);
         r1 = 4'($urandom_range(0, 15));
         r2 = 4'($urandom_range(0, 15));
         r3 = 4'($urandom_range(0, 15));
         if (r1[3:1] == rd[3:1]) r1 = r1 ^ 4'd2;
         if (r2[3:1] == rd[3:1]) r2 = r2 ^ 4'd2;
         if (r3[3:1] == rd[3:1]) r3 = r3 ^ 4'd2;
         imm = $urandom;
         hold = $urandom_range(0, 2);
         early = 1'($urandom_range(0, 1));
         pl(rd, $urandom);
         pl(rd | 4'd1, $urandom);
         pl(r1, $urandom);
         pl(r2, $urandom);
         pl(r3, $urandom);
         legal = (s <= 4'd13);
         b = is_acc(s) ? mir[rd | 4'd1] : mir[r2];
         c = is_acc(s) ? mir[rd] : mir[r3];
         res = op_result(s, mir[r1], b, c, imm);
         run_op(s, r1, r2, r3, rd | 4'(k & 1), imm, hold, early,
                lat, nv, data, err, ra_ok);
         if (legal && s > MP_GTU) begin
            mir[rd] = res[31:0];
            mir[rd | 4'd1] = res[63:32];
         end
         chk($sformatf("r%0d_lat", k), lat, legal ? 1 + op_cycles(s) : 1);
         chk($sformatf("r%0d_err", k), err, !legal);
         chk($sformatf("r%0d_data", k), data,
             (legal && s <= MP_GTU) ? {31'h0, res[0]} : 32'h0);
         chk_regs($sformatf("r%0d_cpr", k));
         if (is_acc(s)) chk($sformatf("r%0d_ra", k), ra_ok, 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
